obi_spi_rx_peripheral: RTL and testbench
========================================

// Module: obi_spi_rx_peripheral
// PURPOSE
//  OBI-mapped SPI target (receive-only): samples external sck_i/mosi_i/cs_ni, assembles MSB-first words,
//  queues them in an RX FIFO read by the core over OBI. Receiving counterpart of obi_spi_peripheral; user domain.
// PARAMETERS
//  ADDR_WIDTH_OBI  32                  OBI address width
//  DATA_WIDTH_OBI  32                  OBI data width
//  ID_WIDTH_OBI    SbrObiCfg.IdWidth   OBI id width
//  SPI_DATA_BITS   8                   bits per received word (2..32)
//  FIFO_DEPTH      4                   RX FIFO entries (power of two, 2..8)
// PORTS
//  clk_i     in   1    system clock
//  rst_ni    in   1    asynchronous active-low reset
//  req_i     in   1    OBI request
//  we_i      in   1    OBI write enable
//  be_i      in   4    OBI byte enables (ignored, full-word access)
//  addr_i    in   ADDR_WIDTH_OBI  OBI address, offset = addr_i[11:0]
//  wdata_i   in   DATA_WIDTH_OBI  OBI write data
//  aid_i     in   ID_WIDTH_OBI    OBI request id
//  gnt_o     out  1    grant, = req_i (combinational)
//  rvalid_o  out  1    response valid, 1 cycle after grant
//  rdata_o   out  DATA_WIDTH_OBI  response data
//  rid_o     out  ID_WIDTH_OBI    response id (latched aid_i)
//  err_o     out  1    response error
//  sck_i     in   1    SPI clock from external initiator (async)
//  mosi_i    in   1    SPI data in (async)
//  cs_ni     in   1    SPI chip select, active low (async)
//  irq_o     out  1    interrupt; present only with OBI_SPI_RX_IRQ_EN
// BEHAVIOUR
//  Reset: rvalid_o/rdata_o/rid_o/err_o/irq_o = 0; CTRL=0; FIFO empty; overflow=0; FSM IDLE; bit_cnt=0.
//  Registers: 0x000 CTRL RW [0]enable [2]CPOL [3]CPHA [4]flush (self-clearing, reads 0).
//   0x004 STATUS RO [0]busy(FSM RECV) [1]rx_valid(!empty) [2]full [3]overflow(sticky) [7:4]level.
//   0x008 DATA_RX RO: pops FIFO head. 0x00C IRQ_EN RW (macro only). Upper unused bits read 0.
//  OBI: grant every req; rvalid_o, rid_o, rdata_o, err_o valid exactly 1 cycle later.
//   err_o=1 for: offset not in map (full 12-bit compare), write to STATUS/DATA_RX; erroneous write has no effect.
//   DATA_RX read: at grant edge head word captured to response reg (zero-extended) and popped; empty -> rdata 0, no pop, no err.
//  Input sync: sck_i/mosi_i/cs_ni each 2-FF synchronised; edge detect on synced sck (prev vs now).
//   Sample edge = synced sck transition to level (~CPOL ^ CPHA); mosi taken from synced copy same cycle.
//   Requirement on initiator: each SCK half-period >= 4 clk_i cycles; CS setup to first edge >= 4 cycles.
//  FSM IDLE -> RECV: synced cs low and enable=1; bit_cnt=0, shifter cleared.
//   RECV, sample edge: shifter={shifter[N-2:0],mosi}; bit_cnt++; at bit_cnt==SPI_DATA_BITS-1 push word, bit_cnt=0, stay RECV.
//   RECV -> IDLE: synced cs high, or enable=0; partial word discarded, bit_cnt=0.
//   CPOL/CPHA writes while busy take effect immediately (software must not do so).
//  FIFO: push when full -> word dropped, overflow=1. Push+pop same cycle -> both occur (also when full).
//   flush=1 written: FIFO emptied, overflow cleared; flush wins over simultaneous push/pop.
//  Reset mid-frame: everything to reset values; resumes on next CS falling edge only.
//  Latency: last SCK sample edge at pin -> STATUS.rx_valid visible <= 4 clk_i cycles.
// CONFIGURATION
//  OBI_SPI_RX_IRQ_EN defined: port irq_o and reg 0x00C IRQ_EN [0]on rx_valid [1]on overflow;
//   irq_o registered = (IRQ_EN[0]&rx_valid)|(IRQ_EN[1]&overflow), level-sensitive, reset 0.
//  Not defined: no irq_o port, no IRQ logic; offset 0x00C is unmapped (err_o=1).
// TESTING
//  Reset then read 0x000/0x004 -> rdata 0, err_o 0, rvalid_o 1 cycle after gnt.
//  CTRL=0x1 (mode 0), CS low, send 0xA5 (SCK half-period 8 clk) -> STATUS=0x13 after frame end... 0x12 after CS high; DATA_RX=0xA5; STATUS[1]=0.
//  CTRL=0xD (mode 3), one CS frame 0x3C,0x81 -> level=2; reads return 0x3C then 0x81; extra read 0x0.
//  Mode 0, send 5 bytes 0x01..0x05, no reads -> STATUS full=1, overflow=1, level=4; reads 0x01..0x04; write CTRL=0x11 -> STATUS=0x00.
//  CS high after 5 bits, then new frame 0x5A -> only 0x5A in FIFO (level=1).
//  Write 0x004, read 0x010, write 0x008 -> err_o=1 each, rid_o=aid_i; with IRQ_EN: IRQ_EN=1, byte received -> irq_o=1 until popped.

Source files
------------

// File: rtl/obi_spi_rx_peripheral.sv
// obi_spi_rx_peripheral: OBI-mapped receive-only SPI target with an RX FIFO.
// Ports: OBI slave (req/gnt, rvalid/rdata/rid/err), SPI pins sck_i/mosi_i/cs_ni;
//   irq_o and IRQ_EN register (0x00C) exist only when OBI_SPI_RX_IRQ_EN is defined.
module obi_spi_rx_peripheral #(
    parameter int unsigned ADDR_WIDTH_OBI = 32,
    parameter int unsigned DATA_WIDTH_OBI = 32,
    parameter int unsigned ID_WIDTH_OBI   = 4,
    parameter int unsigned SPI_DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [3:0]                be_i,
    input  logic [ADDR_WIDTH_OBI-1:0] addr_i,
    input  logic [DATA_WIDTH_OBI-1:0] wdata_i,
    input  logic [ID_WIDTH_OBI-1:0]   aid_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [DATA_WIDTH_OBI-1:0] rdata_o,
    output logic [ID_WIDTH_OBI-1:0]   rid_o,
    output logic                      err_o,
`ifdef OBI_SPI_RX_IRQ_EN
    output logic                      irq_o,
`endif
    input  logic                      sck_i,
    input  logic                      mosi_i,
    input  logic                      cs_ni
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned BW = $clog2(SPI_DATA_BITS);
    localparam int unsigned N  = SPI_DATA_BITS;
    localparam logic [11:0] OFF_CTRL   = 12'h000;
    localparam logic [11:0] OFF_STATUS = 12'h004;
    localparam logic [11:0] OFF_DATA   = 12'h008;
`ifdef OBI_SPI_RX_IRQ_EN
    localparam logic [11:0] OFF_IRQ    = 12'h00C;
`endif

    typedef enum logic {IDLE, RECV} state_e;

    // synchroniser stages, bit order {sck, mosi, cs_n}
    logic [2:0] sync1_q, sync2_q;
    logic       sck_prev_q;
    logic       sck_s, mosi_s, cs_s, sample;

    logic en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d;
    state_e          state_q, state_d;
    logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [N-1:0]    shift_q, shift_d, push_word;
    logic            push, pop, flush;

    logic [N-1:0]    mem_q [FIFO_DEPTH];
    logic [N-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d, empty, full, do_push;

    logic                      rvalid_d, err_d;
    logic [DATA_WIDTH_OBI-1:0] rdata_q, rdata_d, status, head_ext, ctrl_rd;
    logic [ID_WIDTH_OBI-1:0]   rid_q, rid_d;
    logic [11:0]               off;
`ifdef OBI_SPI_RX_IRQ_EN
    logic [1:0] irq_en_q, irq_en_d;
    logic       irq_q, irq_d;
`endif

    logic unused_bits;
    assign unused_bits = ^{be_i, addr_i[ADDR_WIDTH_OBI-1:12],
                           wdata_i[DATA_WIDTH_OBI-1:5], wdata_i[1]};

    assign sck_s  = sync2_q[2];
    assign mosi_s = sync2_q[1];
    assign cs_s   = sync2_q[0];
    // sample edge: synced sck has just moved to level ~CPOL ^ CPHA
    assign sample = (sck_s != sck_prev_q) && (sck_s == (~cpol_q ^ cpha_q));

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(FIFO_DEPTH));
    assign off   = addr_i[11:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        push      = 1'b0;
        push_word = {shift_q[N-2:0], mosi_s};
        unique case (state_q)
            IDLE: begin
                if (!cs_s && en_q) begin
                    state_d   = RECV;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            RECV: begin
                if (cs_s || !en_q) begin
                    state_d   = IDLE;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end else if (sample) begin
                    shift_d = push_word;
                    if (bit_cnt_q == BW'(N - 1)) begin
                        push      = 1'b1;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        status        = '0;
        status[0]     = (state_q == RECV);
        status[1]     = !empty;
        status[2]     = full;
        status[3]     = ovf_q;
        status[7:4]   = 4'(cnt_q);
        head_ext      = '0;
        head_ext[N-1:0] = mem_q[rd_q];
        ctrl_rd       = '0;
        ctrl_rd[0]    = en_q;
        ctrl_rd[2]    = cpol_q;
        ctrl_rd[3]    = cpha_q;
    end

    always_comb begin
        en_d     = en_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        flush    = 1'b0;
        pop      = 1'b0;
        rvalid_d = req_i;
        rdata_d  = '0;
        err_d    = 1'b0;
        rid_d    = req_i ? aid_i : rid_q;
`ifdef OBI_SPI_RX_IRQ_EN
        irq_en_d = irq_en_q;
`endif
        if (req_i) begin
            unique case (off)
                OFF_CTRL: begin
                    if (we_i) begin
                        en_d   = wdata_i[0];
                        cpol_d = wdata_i[2];
                        cpha_d = wdata_i[3];
                        flush  = wdata_i[4];
                    end else begin
                        rdata_d = ctrl_rd;
                    end
                end
                OFF_STATUS: begin
                    if (we_i) err_d = 1'b1;
                    else rdata_d = status;
                end
                OFF_DATA: begin
                    if (we_i) begin
                        err_d = 1'b1;
                    end else if (!empty) begin
                        rdata_d = head_ext;
                        pop     = 1'b1;
                    end
                end
`ifdef OBI_SPI_RX_IRQ_EN
                OFF_IRQ: begin
                    if (we_i) irq_en_d = wdata_i[1:0];
                    else rdata_d = DATA_WIDTH_OBI'(irq_en_q);
                end
`endif
                default: err_d = 1'b1;
            endcase
        end
    end

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        do_push = push && (!full || pop);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else begin
            if (push && !do_push) ovf_d = 1'b1;
            if (do_push) begin
                mem_d[wr_q] = push_word;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(pop);
        end
    end

`ifdef OBI_SPI_RX_IRQ_EN
    assign irq_d = (irq_en_q[0] & !empty) | (irq_en_q[1] & ovf_q);
    assign irq_o = irq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q    <= 3'b001;
            sync2_q    <= 3'b001;
            sck_prev_q <= 1'b0;
            en_q       <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            mem_q      <= '{default: '0};
            wr_q       <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            rvalid_o   <= 1'b0;
            rdata_q    <= '0;
            rid_q      <= '0;
            err_o      <= 1'b0;
        end else begin
            sync1_q    <= {sck_i, mosi_i, cs_ni};
            sync2_q    <= sync1_q;
            sck_prev_q <= sck_s;
            en_q       <= en_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            mem_q      <= mem_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            rvalid_o   <= rvalid_d;
            rdata_q    <= rdata_d;
            rid_q      <= rid_d;
            err_o      <= err_d;
        end
    end

    assign gnt_o   = req_i;
    assign rdata_o = rdata_q;
    assign rid_o   = rid_q;
endmodule

// File: tb/tb_obi_spi_rx_peripheral.sv
// tb_obi_spi_rx_peripheral: randomized bench with a queue-based FIFO model
// and a scoreboard monitor that checks every OBI response.
module tb_obi_spi_rx_peripheral;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = '0, aid = '0;
    logic [31:0] addr = '0, wdata = '0;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;
    logic [3:0]  rid;
    logic        sck = 1'b0, mosi = 1'b0, cs_n = 1'b1;
`ifdef OBI_SPI_RX_IRQ_EN
    logic        irq;
`endif

    obi_spi_rx_peripheral #(
        .ADDR_WIDTH_OBI(32), .DATA_WIDTH_OBI(32), .ID_WIDTH_OBI(4),
        .SPI_DATA_BITS(8), .FIFO_DEPTH(4)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .be_i(be),
        .addr_i(addr), .wdata_i(wdata), .aid_i(aid), .gnt_o(gnt),
        .rvalid_o(rvalid), .rdata_o(rdata), .rid_o(rid), .err_o(err),
`ifdef OBI_SPI_RX_IRQ_EN
        .irq_o(irq),
`endif
        .sck_i(sck), .mosi_i(mosi), .cs_ni(cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [3:0]  id;
        int          due;
        string       name;
    } exp_t;
    exp_t sbq[$];

    // reference model state
    logic       m_en = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0;
    logic       m_cs = 1'b0, m_ovf = 1'b0;
    logic [1:0] m_ie = '0;
    logic [7:0] mq[$];

    function automatic logic [31:0] m_status();
        int n;
        n = mq.size();
        m_status      = '0;
        m_status[0]   = m_cs && m_en;
        m_status[1]   = (n > 0);
        m_status[2]   = (n == 4);
        m_status[3]   = m_ovf;
        m_status[7:4] = 4'(n);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checks++;
            if (rvalid !== 1'b1 || rdata !== e.data || err !== e.err
                || rid !== e.id) begin
                errors++;
                $display("FAIL %s: rvalid=%b rdata=%h err=%b rid=%h, expected rvalid=1 rdata=%h err=%b rid=%h",
                         e.name, rvalid, rdata, err, rid, e.data, e.err, e.id);
            end
        end else if (rvalid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL spurious_rvalid: rvalid=1 at cycle %0d, expected 0", cyc);
        end
    end

    task automatic obi(input logic w, input logic [11:0] off,
                       input logic [31:0] wd, input logic [31:0] ed,
                       input logic ee, input string nm);
        exp_t e;
        @(negedge clk);
        req   = 1'b1;
        we    = w;
        addr  = {20'($urandom), off};
        wdata = wd;
        aid   = 4'($urandom);
        be    = 4'($urandom);
        #1;
        checks++;
        if (gnt !== 1'b1) begin
            errors++;
            $display("FAIL gnt_%s: gnt=%b, expected 1", nm, gnt);
        end
        e.data = ed;
        e.err  = ee;
        e.id   = aid;
        e.due  = cyc + 1;
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        req = 1'b0;
        we  = 1'b0;
    endtask

    task automatic rd(input logic [11:0] off, input string nm);
        logic [31:0] d;
        logic        e;
        d = '0;
        e = 1'b0;
        case (off)
            12'h000: d = {28'b0, m_cpha, m_cpol, 1'b0, m_en};
            12'h004: d = m_status();
            12'h008: if (mq.size() > 0) d = {24'b0, mq.pop_front()};
`ifdef OBI_SPI_RX_IRQ_EN
            12'h00C: d = {30'b0, m_ie};
`endif
            default: e = 1'b1;
        endcase
        obi(1'b0, off, 32'($urandom), d, e, nm);
    endtask

    task automatic wr(input logic [11:0] off, input logic [31:0] wd,
                      input string nm);
        logic e;
        e = 1'b0;
        case (off)
            12'h000: begin
                m_en   = wd[0];
                m_cpol = wd[2];
                m_cpha = wd[3];
                if (wd[4]) begin
                    mq.delete();
                    m_ovf = 1'b0;
                end
            end
`ifdef OBI_SPI_RX_IRQ_EN
            12'h00C: m_ie = wd[1:0];
`endif
            default: e = 1'b1;
        endcase
        obi(1'b1, off, wd, 32'h0, e, nm);
    endtask

    task automatic frame_start();
        sck = m_cpol;
        repeat (4) @(negedge clk);
        cs_n = 1'b0;
        m_cs = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        sck = m_cpol;
        repeat (4) @(negedge clk);
        cs_n = 1'b1;
        m_cs = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    // MSB first; each bit is driven on the non-sampling transition
    task automatic send_bits(input logic [31:0] v, input int n, input int h);
        logic lvl;
        lvl = ~m_cpol ^ m_cpha;
        for (int i = n - 1; i >= 0; i--) begin
            sck  = ~lvl;
            mosi = v[i];
            repeat (h) @(negedge clk);
            sck = lvl;
            repeat (h) @(negedge clk);
        end
        if (n == 8 && m_en && m_cs) begin
            if (mq.size() == 4) m_ovf = 1'b1;
            else mq.push_back(v[7:0]);
        end
    endtask

`ifdef OBI_SPI_RX_IRQ_EN
    task automatic chk_irq(input string nm);
        logic x;
        x = (m_ie[0] && mq.size() > 0) || (m_ie[1] && m_ovf);
        repeat (2) @(negedge clk);
        checks++;
        if (irq !== x) begin
            errors++;
            $display("FAIL %s: irq=%b, expected %b", nm, irq, x);
        end
    endtask
`endif

    initial begin
        #3;
        checks++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || rid !== 4'h0
            || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rvalid=%b rdata=%h rid=%h err=%b, expected all 0",
                     rvalid, rdata, rid, err);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        rd(12'h000, "reset_ctrl");
        rd(12'h004, "reset_status");

        wr(12'h000, 32'h1, "ctrl_mode0");
        frame_start();
        send_bits(32'hA5, 8, 8);
        rd(12'h004, "status_busy_0x13");
        frame_end();
        rd(12'h004, "status_idle_0x12");
        rd(12'h008, "data_a5");
        rd(12'h004, "status_after_pop");

        wr(12'h000, 32'hD, "ctrl_mode3");
        rd(12'h000, "ctrl_readback");
        frame_start();
        send_bits(32'h3C, 8, 6);
        send_bits(32'h81, 8, 6);
        frame_end();
        rd(12'h004, "status_level2");
        rd(12'h008, "data_3c");
        rd(12'h008, "data_81");
        rd(12'h008, "data_empty");

        wr(12'h000, 32'h1, "ctrl_mode0_b");
        frame_start();
        for (int i = 1; i <= 5; i++) send_bits(32'(i), 8, 4);
        frame_end();
        rd(12'h004, "status_full_ovf");
        for (int i = 0; i < 4; i++) rd(12'h008, "data_seq");
        rd(12'h004, "status_ovf_sticky");
        wr(12'h000, 32'h11, "ctrl_flush");
        rd(12'h004, "status_flushed");

        frame_start();
        send_bits(32'h1F, 5, 5);
        frame_end();
        frame_start();
        send_bits(32'h5A, 8, 5);
        frame_end();
        rd(12'h004, "status_partial");
        wr(12'h004, 32'hFF, "err_wr_status");
        wr(12'h008, 32'hFF, "err_wr_data");
        rd(12'h010, "err_rd_010");
        rd(12'h804, "err_rd_804");
        rd(12'h00C, "irq_en_or_err");
        rd(12'h008, "data_5a");

`ifdef OBI_SPI_RX_IRQ_EN
        wr(12'h00C, 32'h1, "irq_en_wr");
        frame_start();
        send_bits(32'hC3, 8, 5);
        frame_end();
        chk_irq("irq_set");
        rd(12'h008, "data_c3");
        chk_irq("irq_clear");
`endif

        for (int it = 0; it < 16; it++) begin
            logic [31:0] c;
            int nw, h;
            nw = $urandom_range(1, 6);
            h  = $urandom_range(4, 9);
            c  = {28'b0, 1'($urandom), 1'($urandom), 2'b01};
            wr(12'h000, c, "ctrl_rand");
            frame_start();
            if ($urandom_range(0, 3) == 0) begin
                send_bits($urandom, $urandom_range(1, 7), h);
                frame_end();
                frame_start();
            end
            for (int w = 0; w < nw; w++) send_bits($urandom, 8, h);
            frame_end();
            rd(12'h004, "status_rand");
            for (int r = $urandom_range(0, 5); r > 0; r--)
                rd(12'h008, "data_rand");
            if ($urandom_range(0, 4) == 0) wr(12'h000, c | 32'h10, "flush_rand");
            rd(12'h004, "status_rand2");
`ifdef OBI_SPI_RX_IRQ_EN
            chk_irq("irq_rand");
`endif
        end

        repeat (4) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pending_responses: %0d outstanding, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
